lb_uart_tx: RTL

Serial transmitter for the UART datapath; counterpart of the team's 11-bit receive shift register. Accepts a byte from the local bus (PicoBlaze output port) with a load strobe, frames it as start, 8 data bits LSB first, parity and stop (11 bits), and shifts it out on `tx_out` at a rate set by a baud divider. Single clock domain; one frame in flight, no FIFO.

---
 rtl/lb_uart_pkg.sv | 23 ++
 rtl/lb_baud_tick.sv | 46 ++++
 rtl/lb_uart_tx.sv | 92 +++++++++
 3 files changed

// File: rtl/lb_uart_pkg.sv
// Shared UART framing definitions used by both the transmit and receive datapaths.
package lb_uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned BIT_CW     = $clog2(FRAME_BITS);

    typedef enum logic {
        IDLE,
        SEND
    } uart_state_e;

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Bit 0 leaves the shift register first: start, data LSB first, parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] d,
                                                          input logic odd);
        return {1'b1, frame_parity(d, odd), d, 1'b0};
    endfunction

endpackage

// File: rtl/lb_baud_tick.sv
// Baud-rate divider: counts 0..DIV-1 while enabled and flags the terminal-count cycle.
module lb_baud_tick #(
    parameter int unsigned DIV = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o,
    output logic tick_next_o
);
    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] TC = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == TC) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // tick is registered from the next count, so it is high exactly while cnt_q == TC.
    assign tick_next_o = (cnt_d == TC);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_next_o;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/lb_uart_tx.sv
// UART transmitter: frames a local-bus byte as start/data/parity/stop and shifts
// it out on tx_out at BAUD_DIV clocks per bit, one frame in flight.
module lb_uart_tx
    import lb_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 434,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 load,
    output logic                 ready,
    output logic                 tx_out,
    output logic                 done
);
    uart_state_e           state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BIT_CW-1:0]     bit_q, bit_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  baud_clr, baud_en;
    logic                  tick, tick_next;

    lb_baud_tick #(
        .DIV(BAUD_DIV)
    ) u_baud (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clr_i      (baud_clr),
        .en_i       (baud_en),
        .tick_o     (tick),
        .tick_next_o(tick_next)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        baud_clr = 1'b0;
        baud_en  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d  = build_frame(data_in, PARITY_ODD);
                    bit_d    = '0;
                    baud_clr = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                baud_en = 1'b1;
                // done is registered, so it is raised one cycle ahead of the last tick.
                done_d  = tick_next && (bit_q == BIT_CW'(FRAME_BITS - 1));
                if (tick) begin
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    if (bit_q == BIT_CW'(FRAME_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + BIT_CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '1;
            bit_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // The shift register refills with ones, so its LSB is also the idle-high line.
    assign tx_out = shift_q[0];
    assign ready  = ready_q;
    assign done   = done_q;

endmodule
